// File: rtl/sd_cmd_sequencer_pkg.sv
// rtl/sd_cmd_sequencer_pkg.sv - shared types and constants for the SD command sequencer
package sd_cmd_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SHIFT = 2'd2
    } seq_state_t;

    localparam logic [1:0] ADDR_DIV    = 2'd0;
    localparam logic [1:0] ADDR_ARG    = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_INDEX_W    = 6;
    localparam int CTRL_START_BIT  = 8;
    localparam int CTRL_CLK_EN_BIT = 9;

    localparam int         FRAME_BITS = 48;
    localparam int         CRC_BITS   = 40;
    localparam logic [6:0] CRC7_POLY  = 7'h09;

endpackage

// File: rtl/sd_cmd_sequencer_if.sv
// rtl/sd_cmd_sequencer_if.sv - Avalon-MM register bus of the SD command sequencer
interface sd_cmd_sequencer_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/sd_cmd_sequencer_crc7.sv
// rtl/sd_cmd_sequencer_crc7.sv - serial CRC7 (x^7+x^3+1), MSB-first data
module sd_crc7
    import sd_cmd_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic       data_in,
    output logic [6:0] crc
);
    logic feedback;

    assign feedback = data_in ^ crc[6];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            crc <= '0;
        end else if (enable) begin
            crc <= {crc[5:0], 1'b0} ^ (feedback ? CRC7_POLY : 7'h00);
        end
    end
endmodule

// File: rtl/sd_cmd_sequencer.sv
// rtl/sd_cmd_sequencer.sv - sends one 48-bit SD command frame on the CMD line per START
module sd_cmd_sequencer
    import sd_cmd_sequencer_pkg::*;
#(
    parameter int DIV_WIDTH = 8,
    parameter int DIV_RESET = 62
) (
    input  logic              clk,
    input  logic              reset,
    sd_cmd_sequencer_if.slave bus,
    output logic              sd_clk,
    output logic              sd_cmd_out,
    output logic              sd_cmd_oe
);
    seq_state_t           state;
    logic [DIV_WIDTH-1:0] div;
    logic [DIV_WIDTH-1:0] div_cnt;
    logic [31:0]          arg;
    logic [5:0]           index;
    logic [5:0]           bit_cnt;
    logic [5:0]           next_k;
    logic [39:0]          frame_sr;
    logic [6:0]           crc;
    logic [2:0]           crc_sel;
    logic                 clk_en, done, armed_stopped;
    logic                 busy, run, wr, fall_evt, start_acc, go_shift;
    logic                 last_bit, load_evt, crc_en, next_bit;

    assign busy      = (state != ST_IDLE);
    assign run       = clk_en | busy;
    assign wr        = bus.chipselect & ~bus.write_n;
    assign fall_evt  = run && sd_clk && (div_cnt >= div);
    assign start_acc = wr && (bus.address == ADDR_CTRL) && bus.writedata[CTRL_START_BIT] && !busy;
    assign go_shift  = (state == ST_ARMED) && (fall_evt || armed_stopped);
    assign last_bit  = (bit_cnt == 6'(FRAME_BITS - 1));
    assign load_evt  = go_shift || ((state == ST_SHIFT) && fall_evt && !last_bit);
    assign next_k    = (state == ST_ARMED) ? 6'd0 : bit_cnt + 6'd1;
    assign crc_en    = load_evt && (next_k < 6'(CRC_BITS));
    assign crc_sel   = 3'(6'(FRAME_BITS - 2) - next_k);

    // The CRC of bits 0..k-1 is complete when bit k is loaded, so bit 40 onward reads it directly.
    always_comb begin
        next_bit = 1'b1;
        if (next_k < 6'(CRC_BITS)) begin
            next_bit = frame_sr[39];
        end else if (next_k != 6'(FRAME_BITS - 1)) begin
            next_bit = crc[crc_sel];
        end
    end

    sd_crc7 u_crc7 (
        .clk     (clk),
        .reset   (reset),
        .clear   (start_acc),
        .enable  (crc_en),
        .data_in (next_bit),
        .crc     (crc)
    );

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_DIV: bus.readdata[DIV_WIDTH-1:0] = div;
            ADDR_ARG: bus.readdata = arg;
            ADDR_CTRL: begin
                bus.readdata[CTRL_CLK_EN_BIT]    = clk_en;
                bus.readdata[CTRL_INDEX_W-1:0]   = index;
            end
            default: bus.readdata[1:0] = {done, busy};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            div           <= DIV_WIDTH'(DIV_RESET);
            div_cnt       <= '0;
            arg           <= '0;
            index         <= '0;
            clk_en        <= 1'b0;
            done          <= 1'b0;
            armed_stopped <= 1'b0;
            bit_cnt       <= '0;
            frame_sr      <= '0;
            sd_clk        <= 1'b0;
            sd_cmd_out    <= 1'b1;
            sd_cmd_oe     <= 1'b0;
        end else begin
            // Entering SHIFT always restarts the divider so the first bit gets a full period.
            if (go_shift || !run) begin
                div_cnt <= '0;
                sd_clk  <= 1'b0;
            end else if (div_cnt >= div) begin
                div_cnt <= '0;
                sd_clk  <= ~sd_clk;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (wr && !busy && bus.address == ADDR_DIV) div <= bus.writedata[DIV_WIDTH-1:0];
            if (wr && !busy && bus.address == ADDR_ARG) arg <= bus.writedata;
            if (wr && bus.address == ADDR_CTRL) begin
                index  <= bus.writedata[CTRL_INDEX_W-1:0];
                clk_en <= bus.writedata[CTRL_CLK_EN_BIT];
            end

            if ((state == ST_SHIFT) && fall_evt && last_bit) begin
                done <= 1'b1;
            end else if (start_acc || (wr && bus.address == ADDR_STATUS)) begin
                done <= 1'b0;
            end

            if (load_evt) begin
                bit_cnt    <= next_k;
                sd_cmd_out <= next_bit;
                frame_sr   <= {frame_sr[38:0], 1'b0};
            end

            case (state)
                ST_IDLE: begin
                    if (start_acc) begin
                        state         <= ST_ARMED;
                        armed_stopped <= !run;
                        frame_sr      <= {2'b01, bus.writedata[CTRL_INDEX_W-1:0], arg};
                    end
                end
                ST_ARMED: begin
                    if (go_shift) begin
                        state     <= ST_SHIFT;
                        sd_cmd_oe <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (fall_evt && last_bit) begin
                        state      <= ST_IDLE;
                        sd_cmd_oe  <= 1'b0;
                        sd_cmd_out <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// tb/tb_sd_cmd_sequencer.sv - scoreboard bench for sd_cmd_sequencer
module tb_sd_cmd_sequencer;
    import sd_cmd_sequencer_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sd_clk, sd_cmd_out, sd_cmd_oe;

    sd_cmd_sequencer_if bus();

    sd_cmd_sequencer #(.DIV_WIDTH(8), .DIV_RESET(62)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .sd_clk     (sd_clk),
        .sd_cmd_out (sd_cmd_out),
        .sd_cmd_oe  (sd_cmd_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] frame;
        int          div;
        bit          free_run;
        bit          abort;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    int          m_div = 62;
    logic [31:0] m_arg = '0;
    logic [5:0]  m_idx = '0;
    bit          m_ce  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Long-division CRC: remainder of M(x)*x^7 over x^7+x^3+1.
    function automatic logic [47:0] model_frame(input logic [5:0] idx, input logic [31:0] a);
        logic [39:0] m;
        logic [46:0] r;
        m = {2'b01, idx, a};
        r = {m, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        end
        return {m, r[6:0], 1'b1};
    endfunction

    task automatic push_exp(input logic [47:0] f, input int d, input bit fr, input bit ab);
        exp_t e;
        e.frame = f; e.div = d; e.free_run = fr; e.abort = ab;
        exp_q.push_back(e);
    endtask

    // Frame monitor: captures CMD bits on sd_clk rising edges and checks timing.
    exp_t        cur;
    bit          have = 1'b0;
    logic        p_oe = 1'b0, p_clk = 1'b0, p_out = 1'b1;
    logic [47:0] bits;
    int          nbits, flen, phase, tim_err;

    always @(negedge clk) begin
        if (sd_cmd_oe && !p_oe) begin
            nbits = 0; bits = '0; flen = 1; phase = 1; tim_err = 0;
            if (exp_q.size() == 0) begin
                have = 1'b0;
                checks++; errors++;
                $display("FAIL unexpected_frame: frame started with no START pending");
            end else begin
                cur  = exp_q.pop_front();
                have = 1'b1;
                if (!cur.abort) begin
                    check("first_bit_clk_low", sd_clk, 1'b0);
                    check("first_bit_after_fall", p_clk, cur.free_run);
                end
            end
        end else if (sd_cmd_oe) begin
            flen++;
            if (sd_clk != p_clk) begin
                if (have && phase != cur.div + 1) tim_err++;
                phase = 1;
            end else begin
                phase++;
            end
            if (sd_cmd_out != p_out && !(p_clk && !sd_clk)) tim_err++;
        end
        if (sd_cmd_oe && sd_clk && !p_clk) begin
            bits = {bits[46:0], sd_cmd_out};
            nbits++;
        end
        if (!sd_cmd_oe && p_oe && have && !cur.abort) begin
            check("frame_bits", bits, cur.frame);
            check("frame_nbits", nbits, 48);
            check("frame_len", flen, 96 * (cur.div + 1));
            check("bit_timing", tim_err, 0);
            have = 1'b0;
        end
        p_oe = sd_cmd_oe; p_clk = sd_clk; p_out = sd_cmd_out;
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        @(posedge clk); #1;
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
        #1 d = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    task automatic check_reg(input string name, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    task automatic wait_oe();
        bit ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (sd_cmd_oe) ok = 1'b1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL wait_oe: oe=0 after 3000 cycles, required 1");
        end
    endtask

    task automatic wait_idle();
        logic [31:0] s;
        bit ok = 1'b0;
        for (int i = 0; i < 5000 && !ok; i++) begin
            @(negedge clk);
            bus_read(ADDR_STATUS, s);
            if (!s[0]) ok = 1'b1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL wait_idle: BUSY=1 after 5000 cycles, required 0");
        end
    endtask

    task automatic start_frame(input int d, input logic [5:0] idx, input logic [31:0] a, input bit ce);
        bus_write(ADDR_DIV, 32'(d));
        bus_write(ADDR_ARG, a);
        m_div = d; m_arg = a;
        push_exp(model_frame(idx, a), d, m_ce, 1'b0);
        bus_write(ADDR_CTRL, (32'(ce) << 9) | 32'h100 | 32'(idx));
        m_idx = idx; m_ce = ce;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check_reg("reset_div", ADDR_DIV, 32'd62);
        check_reg("reset_arg", ADDR_ARG, 32'd0);
        check_reg("reset_ctrl", ADDR_CTRL, 32'd0);
        check_reg("reset_status", ADDR_STATUS, 32'd0);
        check("reset_oe", sd_cmd_oe, 1'b0);
        check("reset_out", sd_cmd_out, 1'b1);
        check("reset_sd_clk", sd_clk, 1'b0);

        // CMD0 at DIV=0
        bus_write(ADDR_DIV, 32'd0);
        bus_write(ADDR_ARG, 32'd0);
        m_div = 0;
        push_exp(48'h40_0000_0000_95, 0, 1'b0, 1'b0);
        bus_write(ADDR_CTRL, 32'h100);
        wait_oe();
        check_reg("cmd0_busy", ADDR_STATUS, 32'd1);
        wait_idle();
        check_reg("cmd0_done", ADDR_STATUS, 32'd2);
        bus_write(ADDR_STATUS, 32'd0);
        check_reg("done_cleared", ADDR_STATUS, 32'd0);

        // CMD8 at DIV=3, with writes attempted mid-frame
        bus_write(ADDR_DIV, 32'd3);
        bus_write(ADDR_ARG, 32'h1AA);
        m_div = 3; m_arg = 32'h1AA;
        push_exp(48'h48_0000_01AA_87, 3, 1'b0, 1'b0);
        bus_write(ADDR_CTRL, 32'h108);
        m_idx = 6'h08;
        wait_oe();
        repeat (100) @(negedge clk);
        bus_write(ADDR_CTRL, 32'h111);
        m_idx = 6'h11;
        bus_write(ADDR_DIV, 32'd7);
        bus_write(ADDR_ARG, 32'hDEAD);
        check_reg("cmd8_busy_mid", ADDR_STATUS, 32'd1);
        wait_idle();
        check_reg("div_write_ignored", ADDR_DIV, 32'(m_div));
        check_reg("arg_write_ignored", ADDR_ARG, m_arg);
        check_reg("ctrl_index", ADDR_CTRL, 32'h11);
        repeat (300) @(negedge clk);
        check("no_second_frame_oe", sd_cmd_oe, 1'b0);
        check_reg("no_second_frame_status", ADDR_STATUS, 32'd2);

        // Free-running divider, then START
        bus_write(ADDR_DIV, 32'd4);
        m_div = 4;
        bus_write(ADDR_CTRL, 32'h200);
        m_ce = 1'b1; m_idx = '0;
        repeat (13) @(negedge clk);
        start_frame(4, 6'h05, 32'hA5C3_0F17, 1'b1);
        wait_idle();
        check_reg("free_run_ctrl", ADDR_CTRL, 32'h205);

        // STATUS write landing on the DONE-set edge
        bus_write(ADDR_CTRL, 32'h000);
        m_ce = 1'b0; m_idx = '0;
        repeat (4) @(negedge clk);
        start_frame(1, 6'h11, 32'h1234_5678, 1'b0);
        wait_oe();
        repeat (96 * 2 - 1) @(negedge clk);
        bus_write(ADDR_STATUS, 32'd0);
        check("frame_end_exact", sd_cmd_oe, 1'b0);
        check_reg("done_wins_over_clear", ADDR_STATUS, 32'd2);

        // Reset in bit 20
        bus_write(ADDR_DIV, 32'd2);
        m_div = 2;
        push_exp(model_frame(6'h2A, m_arg), 2, 1'b0, 1'b1);
        bus_write(ADDR_CTRL, 32'h12A);
        wait_oe();
        repeat (20 * 6 + 2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_oe", sd_cmd_oe, 1'b0);
        check("abort_sd_clk", sd_clk, 1'b0);
        check("abort_out", sd_cmd_out, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        m_div = 62; m_arg = '0; m_idx = '0; m_ce = 1'b0;
        check_reg("abort_status", ADDR_STATUS, 32'd0);
        check_reg("abort_div", ADDR_DIV, 32'd62);
        start_frame(2, 6'h37, 32'hCAFE_0001, 1'b0);
        wait_idle();
        check_reg("after_abort_done", ADDR_STATUS, 32'd2);

        // Randomized frames
        for (int n = 0; n < 8; n++) begin
            int          d;
            logic [5:0]  idx;
            logic [31:0] a;
            bit          ce;
            d   = int'($urandom_range(0, 5));
            idx = 6'($urandom_range(0, 63));
            a   = $urandom;
            ce  = 1'($urandom_range(0, 1));
            bus_write(ADDR_CTRL, 32'(ce) << 9);
            m_ce = ce; m_idx = '0;
            repeat ($urandom_range(0, 7)) @(negedge clk);
            start_frame(d, idx, a, ce);
            wait_idle();
            check_reg("rand_status", ADDR_STATUS, 32'd2);
            check_reg("rand_ctrl", ADDR_CTRL, (32'(m_ce) << 9) | 32'(m_idx));
            check_reg("rand_div", ADDR_DIV, 32'(m_div));
        end

        repeat (50) @(negedge clk);
        check("pending_frames", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sd_cmd_sequencer.md
SD_CMD_SEQUENCER -- requirements
Module: sd_cmd_sequencer

Interface
REQ-001 Parameter: DIV_WIDTH, 8, width of the clock-divider register.
REQ-002 Parameter: DIV_RESET, 62, divider reset value (about 400 kHz sd_clk from 50 MHz clk).
REQ-003 Port: clk  in  1  system clock; the single clock domain.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: address  in  2  Avalon-MM slave word address.
REQ-006 Port: chipselect  in  1  slave select.
REQ-007 Port: write_n  in  1  active-low write strobe.
REQ-008 Port: writedata  in  32  write data.
REQ-009 Port: readdata  out  32  read data; zero wait states, combinational from address.
REQ-010 Port: sd_clk  out  1  SD card clock.
REQ-011 Port: sd_cmd_out  out  1  CMD line drive value.
REQ-012 Port: sd_cmd_oe  out  1  CMD line output enable (1 = drive).

Function
REQ-013 A write is chipselect && !write_n; reads have no side effects.
REQ-014 Register map:
- addr0 DIV[DIV_WIDTH-1:0], read/write.
- addr1 ARG[31:0], read/write.
- addr2 CTRL: write bits [5:0] INDEX, bit 8 START (self-clearing), bit 9 CLK_EN; read returns {CLK_EN at bit 9, INDEX at bits [5:0]}.
- addr3 STATUS: read bit0 BUSY, bit1 DONE; any write clears DONE.
- Unused read bits return 0.
REQ-015 The divider shall toggle sd_clk every DIV+1 clk cycles, giving a period of 2*(DIV+1).
REQ-016 The divider shall run when CLK_EN=1 or BUSY=1; otherwise sd_clk holds 0 and the counter holds 0.
REQ-017 States: IDLE, ARMED, SHIFT.
- IDLE -> ARMED on a CTRL write with START=1. INDEX and ARG are snapshotted into the frame register; DONE clears.
- ARMED -> SHIFT on the next sd_clk falling-edge event, or on the next cycle if the divider was stopped (the divider then restarts from 0 with sd_clk=0).
- SHIFT -> IDLE after the 48th bit has been held for one full sd_clk period. On that cycle DONE sets.
REQ-018 BUSY=1 in ARMED and SHIFT.
REQ-019 Frame, MSB first, 48 bits:
- 0 (start), 1 (transmission), INDEX[5:0], ARG[31:0], CRC7[6:0], 1 (end).
REQ-020 CRC7 uses polynomial x^7+x^3+1, initial value 0, over the first 40 frame bits.
REQ-021 In SHIFT, sd_cmd_oe=1. sd_cmd_out changes only on sd_clk falling-edge events, so each bit is stable across one rising edge and lasts exactly 2*(DIV+1) clk cycles.
REQ-022 Outside SHIFT, sd_cmd_oe=0 and sd_cmd_out=1.
REQ-023 A START write while BUSY=1 shall be ignored.
REQ-024 Writes to DIV and ARG while BUSY=1 shall be ignored.
REQ-025 A CLK_EN write is accepted at any time but takes effect on the divider only when BUSY=0.
REQ-026 If a STATUS write coincides with the cycle DONE sets, DONE shall end at 1.
REQ-027 DIV=0 is legal: sd_clk = clk/2 and each bit lasts 2 cycles.

Reset
REQ-028 On reset, all state shall clear at the next clk edge, including any frame in progress.
REQ-029 Reset values:
- state IDLE, BUSY=0, DONE=0, CLK_EN=0, DIV=DIV_RESET, ARG=0, INDEX=0.
- sd_clk=0, sd_cmd_oe=0, sd_cmd_out=1, divider counter 0.
REQ-030 Reset mid-frame shall release the CMD line (oe=0) in the first cycle after the reset edge.

Structure
REQ-031 A shared package shall hold the state enumeration, the register address constants, the CTRL bit positions, FRAME_BITS=48 and CRC7_POLY=7'h09.
REQ-032 One sub-module, sd_crc7, shall compute a serial CRC7 with inputs clk, reset, clear, enable, data_in and output crc[6:0].

Verification
REQ-033 Reset, then read all four addresses: DIV=62, ARG=0, CTRL=0, STATUS=0; sd_cmd_oe=0, sd_cmd_out=1, sd_clk=0.
REQ-034 DIV=0, INDEX=0, ARG=0, START: captured frame is 0x40_0000_0000_95; BUSY is high for the frame; the DONE bit reads 1 afterwards.
REQ-035 DIV=3, INDEX=8, ARG=0x000001AA, START: frame is 0x48_0000_01AA_87; every bit lasts 8 cycles; frame lasts 384 cycles from the first oe=1.
REQ-036 Second START and a DIV write issued mid-frame: the frame is unaltered, DIV still reads the old value, and no second frame follows.
REQ-037 CLK_EN=1 with DIV=4 (free-running), then START: the first bit appears on a falling-edge event and sd_clk shows no glitch.
REQ-038 Assert reset at bit 20 of a frame: oe=0 the next cycle, sd_clk=0, BUSY=0; a new START afterwards sends a complete, correct frame.
